// File: rtl/am29xx_cla_pipe.sv
// am29xx_cla_pipe -- pipelined carry-lookahead generator (Am2902-class).
// Combinational lookahead across GROUPS slice groups, results captured into a
// DEPTH-entry output FIFO with valid/ready handshake.
// Optional feature macro: CLA_CARRY_CHAIN_EN -- enables the multiprecision
// carry-chain register; without it the chain input is ignored and ci = cn.
module am29xx_cla_pipe #(
  parameter int GROUPS = 4,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              cn,
  input  logic [GROUPS-1:0] g_,
  input  logic [GROUPS-1:0] p_,
  input  logic              chain,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [GROUPS-1:0] c,
  output logic              go_,
  output logic              po_,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [GROUPS-1:0] mem_c  [DEPTH];
  logic              mem_go [DEPTH];
  logic              mem_po [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;

  logic              ci;
  logic              k;
  logic              gen;
  logic [GROUPS-1:0] c_nxt;
  logic              go_nxt;
  logic              po_nxt;
  logic              push;
  logic              pop;

  assign in_ready  = (count != CNT_FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

`ifdef CLA_CARRY_CHAIN_EN
  logic carry_reg;

  // Remember the word carry-out of every accepted word for the next chained word.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      carry_reg <= 1'b0;
    end else if (push) begin
      carry_reg <= c_nxt[GROUPS-1];
    end
  end

  assign ci = chain ? carry_reg : cn;
`else
  wire unused_chain = chain;

  assign ci = cn;
`endif

  // Ripple-free lookahead: group carries from ci, plus group generate/propagate
  // which are independent of ci (generate is evaluated with a zero carry in).
  always_comb begin
    k     = ci;
    gen   = 1'b0;
    c_nxt = '0;
    for (int j = 0; j < GROUPS; j++) begin
      k        = ~g_[j] | (~p_[j] & k);
      c_nxt[j] = k;
      gen      = ~g_[j] | (~p_[j] & gen);
    end
    go_nxt = ~gen;
    po_nxt = |p_;
  end

  // Output FIFO: write at accept edge, read from head; pointers wrap at DEPTH-1.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_c[i]  <= '0;
        mem_go[i] <= 1'b1;
        mem_po[i] <= 1'b1;
      end
    end else begin
      if (push) begin
        mem_c[wr_ptr]  <= c_nxt;
        mem_go[wr_ptr] <= go_nxt;
        mem_po[wr_ptr] <= po_nxt;
        wr_ptr         <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign c   = mem_c[rd_ptr];
  assign go_ = mem_go[rd_ptr];
  assign po_ = mem_po[rd_ptr];

endmodule
